// File: rtl/fcmp_max_reduce.sv
// fcmp_max_reduce: streaming max-reduction of WINDOW FloPoCo floats, with the index of the winner and a NaN flag.
// fcmplt is the combinational less-than comparator used for the running compare.
module fcmplt #(
    parameter int WE = 4,
    parameter int WF = 3
) (
    input  logic [WE+WF+2:0] x,
    input  logic [WE+WF+2:0] y,
    output logic             xlty
);
    logic [1:0]       ex, ey;
    logic [WE+WF+1:0] mx, my;
    logic             nx, ny, nan;
    assign ex  = x[WE+WF+2:WE+WF+1];
    assign ey  = y[WE+WF+2:WE+WF+1];
    // Magnitude key orders zero < normal < inf; both zeros map to the same key.
    assign mx  = {ex, ex == 2'b01 ? x[WE+WF-1:0] : (WE+WF)'(0)};
    assign my  = {ey, ey == 2'b01 ? y[WE+WF-1:0] : (WE+WF)'(0)};
    assign nx  = x[WE+WF] & |ex;
    assign ny  = y[WE+WF] & |ey;
    assign nan = &ex | &ey;
    assign xlty = ~nan & (nx != ny ? nx : (nx ? mx > my : mx < my));
endmodule

module fcmp_max_reduce #(
    parameter int WE     = 4,
    parameter int WF     = 3,
    parameter int WINDOW = 4,
    parameter int IDX_W  = $clog2(WINDOW)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WE+WF+2:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WE+WF+2:0]    out_max,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_nan
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     count_q, count_d, run_idx_q, run_idx_d, out_idx_q, out_idx_d;
    logic [WE+WF+2:0]     run_max_q, run_max_d, out_max_q, out_max_d;
    logic                 run_nan_q, run_nan_d, out_nan_q, out_nan_d, out_valid_q, out_valid_d;
    logic                 in_fire, in_nan, xlty, upd;
    logic [WE+WF+2:0]     nxt_max;
    logic [IDX_W-1:0]     nxt_idx;

    fcmplt #(.WE(WE), .WF(WF)) u_cmp (.x(run_max_q), .y(in_data), .xlty(xlty));

    assign in_ready  = ~out_valid_q | out_ready;
    assign in_fire   = in_valid & in_ready;
    assign in_nan    = &in_data[WE+WF+2:WE+WF+1];
    // Once a NaN is captured the running result is frozen.
    assign upd       = ~run_nan_q & (in_nan | xlty);
    assign nxt_max   = upd ? in_data : run_max_q;
    assign nxt_idx   = upd ? count_q : run_idx_q;
    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_idx   = out_idx_q;
    assign out_nan   = out_nan_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        run_nan_d   = run_nan_q;
        out_max_d   = out_max_q;
        out_idx_d   = out_idx_q;
        out_nan_d   = out_nan_q;
        out_valid_d = out_valid_q & ~out_ready;
        if (in_fire && state_q == IDLE) begin
            run_max_d = in_data;
            run_idx_d = '0;
            run_nan_d = in_nan;
            count_d   = IDX_W'(1);
            state_d   = ACCUM;
        end else if (in_fire) begin
            run_max_d = nxt_max;
            run_idx_d = nxt_idx;
            run_nan_d = run_nan_q | in_nan;
            count_d   = count_q + IDX_W'(1);
            if (count_q == IDX_W'(WINDOW - 1)) begin
                out_max_d   = nxt_max;
                out_idx_d   = nxt_idx;
                out_nan_d   = run_nan_q | in_nan;
                out_valid_d = 1'b1;
                count_d     = '0;
                state_d     = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            run_max_q   <= '0;
            run_idx_q   <= '0;
            run_nan_q   <= 1'b0;
            out_max_q   <= '0;
            out_idx_q   <= '0;
            out_nan_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            run_nan_q   <= run_nan_d;
            out_max_q   <= out_max_d;
            out_idx_q   <= out_idx_d;
            out_nan_q   <= out_nan_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: doc/fcmp_max_reduce.md
Name: fcmp_max_reduce

Overview:
- Sequential max-reduction unit for FloPoCo-format floats (exception bits, then sign, exponent, fraction). Used for maxpool windows and reduce-max nodes emitted by the scheduler.
- Accepts a stream of WINDOW operands over a valid/ready handshake. Tracks a running maximum and its index using one combinational fcmplt instance, parameterised to WE/WF.
- Emits the maximum, its index and a NaN flag over a second valid/ready handshake.

Parameters:
- WE, 4, exponent width; must match the fcmplt instance.
- WF, 3, fraction width; must match the fcmplt instance.
- WINDOW, 4, operands per reduction; legal range 2..256.
- IDX_W, $clog2(WINDOW), width of the index output.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  WE+WF+3  operand: [WE+WF+2:WE+WF+1] exception (00 zero, 01 normal, 10 inf, 11 NaN), then sign, exponent, fraction.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_max  out  WE+WF+3  maximum of the window.
- out_idx  out  IDX_W  position (0-based) of the selected operand within the window.
- out_nan  out  1  at least one NaN operand was in the window.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, count=0, out_valid=0, out_max=0, out_idx=0, out_nan=0, internal running max/idx/nan=0. Reset takes effect mid-window and mid-output; the partial window is discarded.
- Accept condition: in_fire = in_valid & in_ready. Output transfer: out_fire = out_valid & out_ready.
- in_ready = ~out_valid | out_ready, so a new window starts in the same cycle the previous result drains.
- FSM:
  - IDLE: on in_fire, load run_max=in_data, run_idx=0, run_nan=(exc==11), count=1, go to ACCUM.
  - ACCUM: on in_fire, count increments; compare with fcmplt(X=run_max, Y=in_data).
  - Replace run_max/run_idx with in_data/count when XltY=1 and run_nan=0.
  - If in_data is NaN and run_nan=0: set run_nan=1, run_max=in_data, run_idx=count. After that, run_max and run_idx are frozen.
  - On the in_fire where count==WINDOW-1: register the final result (including this operand) into out_max/out_idx/out_nan, set out_valid=1, count=0, go to IDLE.
  - No in_fire in a cycle: state is held.
- Latency: out_valid rises on the clk edge that accepts the last operand, i.e. it is visible the cycle after that operand is presented. Throughput is one operand per cycle with no bubble between windows when out_ready=1.
- Output hold: out_valid, out_max, out_idx and out_nan are stable until out_fire.
  - out_fire with no new completion in the same cycle: out_valid=0.
  - out_fire in the same cycle another window completes (only possible when WINDOW≥2 and that window started earlier): out registers load the new result and out_valid stays 1.
- Ties (equal values, or +0 vs -0): XltY=0, so the earliest index is kept.
- Infinity ordering follows fcmplt: -inf < normals/zeros < +inf.
- in_data is ignored while in_valid=0. in_valid/in_data must stay stable while in_ready=0 (checked by assertion in the bench).

Test Plan:
- WE=4, WF=3, WINDOW=4, out_ready=1. Feed 0x138 (1.0), 0x140 (2.0), 0x13C (1.5), 0x1B8 (-1.0) on consecutive cycles -> one cycle after the 4th: out_valid=1, out_max=0x140, out_idx=1, out_nan=0.
- Feed 0x280 (-inf), 0x1B8, 0x080 (-0), 0x000 (+0) -> out_max=0x080, out_idx=2 (tie keeps earlier), out_nan=0.
- Feed 0x138, 0x300 (NaN), 0x200 (+inf), 0x140 -> out_max=0x300, out_idx=1, out_nan=1.
- Hold out_ready=0 after a result; present a full second window -> in_ready=0 from the first cycle of the second window. First result is stable. Raise out_ready -> first result drains, second window is accepted back-to-back, and its result is correct.
- Random in_valid gaps (50%) over 1000 windows of random encodings -> results match a reference model using fcmplt semantics; no lost or duplicated outputs.
- Assert rst_n=0 after 2 operands of a window, then feed 4 fresh operands -> all outputs are 0 during reset; the result reflects only the fresh 4 operands with out_idx relative to them.
